// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, with the round keys
// rebuilt backwards on the fly from the round-10 encryption key.
module aes_inv_cipher (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic [127:0] iCipherText,
    input  logic [127:0] iLastRoundKey,
    output logic         oBusy,
    output logic         oDone,
    output logic [127:0] oPlainText
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm;
    logic [127:0] state;
    logic [127:0] key;
    logic [3:0]   rnd;

    logic [127:0] prev_key;
    logic [127:0] shifted;
    logic [127:0] t;
    logic [127:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Reverse key step; rcon() takes rnd directly since it indexes Rcon[rnd+1].
    always_comb begin
        logic [31:0] w3n;
        w3n = key[31:0] ^ key[63:32];
        prev_key = 128'h0;
        prev_key[31:0]   = w3n;
        prev_key[63:32]  = key[63:32] ^ key[95:64];
        prev_key[95:64]  = key[95:64] ^ key[127:96];
        prev_key[127:96] = key[127:96] ^ sub_word({w3n[23:0], w3n[31:24]})
                           ^ {rcon(rnd), 24'h0};
    end

    // Byte (r, c) sits at index r + 4c, MSB first; row r rotates right by r.
    always_comb begin
        shifted = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(r + 4*c) -: 8] =
                    inv_sbox(state[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
            end
        end
        t = shifted ^ prev_key;
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mixed = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127 - 32*c -: 8];
            a1 = t[119 - 32*c -: 8];
            a2 = t[111 - 32*c -: 8];
            a3 = t[103 - 32*c -: 8];
            mixed[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                   ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            mixed[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                   ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            mixed[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                   ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            mixed[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                   ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end

    // The key register also steps on the final round so it ends holding the cipher key.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fsm        <= IDLE;
            state      <= 128'h0;
            key        <= 128'h0;
            rnd        <= 4'd0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oPlainText <= 128'h0;
        end else begin
            oDone <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (iStart) begin
                        state <= iCipherText ^ iLastRoundKey;
                        key   <= iLastRoundKey;
                        rnd   <= 4'd9;
                        oBusy <= 1'b1;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    key <= prev_key;
                    if (rnd != 4'd0) begin
                        state <= mixed;
                        rnd   <= rnd - 4'd1;
                    end else begin
                        oPlainText <= t;
                        oDone      <= 1'b1;
                        oBusy      <= 1'b0;
                        fsm        <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed testbench for aes_inv_cipher: known-answer vectors plus busy-protection,
// back-to-back and mid-block reset sequences.
module tb_aes_inv_cipher;

    logic         iClk;
    logic         iRst_n;
    logic         iStart;
    logic [127:0] iCipherText;
    logic [127:0] iLastRoundKey;
    logic         oBusy;
    logic         oDone;
    logic [127:0] oPlainText;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [127:0] ct;
        logic [127:0] lk;
        logic [127:0] pt;
        logic [127:0] k0;
    } vec_t;

    vec_t vecs[3];

    localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_LK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;

    aes_inv_cipher dut (
        .iClk          (iClk),
        .iRst_n        (iRst_n),
        .iStart        (iStart),
        .iCipherText   (iCipherText),
        .iLastRoundKey (iLastRoundKey),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oPlainText    (oPlainText)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // oBusy and oDone must never be high together.
    always @(negedge iClk) begin
        if (iRst_n && oBusy && oDone) begin
            errors++;
            $display("[TB] FAIL busy_done_overlap busy=%b done=%b required not both 1", oBusy, oDone);
        end
    end

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    // Presents a block at the next negedge and leaves 1ns after the sampling edge.
    task automatic apply_stimulus(input logic [127:0] ct, input logic [127:0] lk);
        @(negedge iClk);
        iStart        = 1'b1;
        iCipherText   = ct;
        iLastRoundKey = lk;
        @(posedge iClk);
        #1;
        iStart        = 1'b0;
        iCipherText   = '0;
        iLastRoundKey = '0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!oDone && edges < 30) begin
            @(posedge iClk);
            #1;
            edges++;
        end
    endtask

    task automatic check_output(input string name, input int edges, input int exp_edges,
                                input logic [127:0] pt, input logic [127:0] k0);
        check({name, "_latency"}, 128'(edges), 128'(exp_edges));
        check({name, "_done"}, 128'(oDone), 128'd1);
        check({name, "_busy_low"}, 128'(oBusy), 128'd0);
        check({name, "_plaintext"}, oPlainText, pt);
        check({name, "_round0_key"}, dut.key, k0);
    endtask

    initial begin
        int edges;
        int pulses;

        vecs[0] = '{"fips_b", B_CT, B_LK, B_PT, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{"fips_c1", C_CT, C_LK, C_PT, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[2] = '{"zero_key", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0, 128'h0};

        iRst_n        = 1'b0;
        iStart        = 1'b0;
        iCipherText   = '0;
        iLastRoundKey = '0;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_busy", 128'(oBusy), 128'd0);
        check("reset_done", 128'(oDone), 128'd0);
        check("reset_plaintext", oPlainText, 128'h0);
        check("reset_rnd", 128'(dut.rnd), 128'd0);
        @(negedge iClk);
        iRst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(vecs[i].ct, vecs[i].lk);
            check({vecs[i].name, "_busy_high"}, 128'(oBusy), 128'd1);
            wait_done(edges);
            check_output(vecs[i].name, edges, 10, vecs[i].pt, vecs[i].k0);
            @(posedge iClk);
            #1;
            check({vecs[i].name, "_done_pulse"}, 128'(oDone), 128'd0);
            check({vecs[i].name, "_hold"}, oPlainText, vecs[i].pt);
        end

        // Start during the App. B run must be ignored.
        apply_stimulus(B_CT, B_LK);
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        iStart        = 1'b1;
        iCipherText   = C_CT;
        iLastRoundKey = C_LK;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        check("busy_prot_still_busy", 128'(oBusy), 128'd1);
        wait_done(edges);
        check("busy_prot_latency", 128'(edges), 128'd6);
        check("busy_prot_plaintext", oPlainText, B_PT);
        pulses = 0;
        repeat (15) begin
            @(posedge iClk);
            #1;
            if (oDone) pulses++;
        end
        check("busy_prot_extra_done", 128'(pulses), 128'd0);

        // Restart on the oDone cycle: second completion 11 edges after the first.
        apply_stimulus(B_CT, B_LK);
        wait_done(edges);
        check("b2b_first_plaintext", oPlainText, B_PT);
        iStart        = 1'b1;
        iCipherText   = C_CT;
        iLastRoundKey = C_LK;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        check("b2b_accept_busy", 128'(oBusy), 128'd1);
        check("b2b_hold_first", oPlainText, B_PT);
        wait_done(edges);
        check("b2b_second_latency", 128'(edges + 1), 128'd11);
        check("b2b_second_plaintext", oPlainText, C_PT);

        // Reset in the middle of a block clears outputs immediately.
        apply_stimulus(B_CT, B_LK);
        repeat (4) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(oBusy), 128'd0);
        check("midrst_done", 128'(oDone), 128'd0);
        check("midrst_plaintext", oPlainText, 128'h0);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge iClk);
            #1;
            if (oDone) pulses++;
        end
        check("midrst_no_done", 128'(pulses), 128'd0);
        check("midrst_plaintext_after", oPlainText, 128'h0);
        apply_stimulus(C_CT, C_LK);
        wait_done(edges);
        check_output("midrst_restart", edges, 10, C_PT, 128'h000102030405060708090a0b0c0d0e0f);

        @(posedge iClk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
